// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: one-cycle capture of execute-stage results with
// stall/flush control, control-bit sanitizing and a saturating bubble counter.
module ex_mem_register #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Stall,
   input  logic                  Flush,
   input  logic                  Valid_in,
   input  logic [DATA_WIDTH-1:0] ALUResult_in,
   input  logic                  Zero_in,
   input  logic [DATA_WIDTH-1:0] BranchTarget_in,
   input  logic [DATA_WIDTH-1:0] WriteData_in,
   input  logic [4:0]            RegDst_in,
   input  logic                  RegWrite_in,
   input  logic                  MemRead_in,
   input  logic                  MemWrite_in,
   input  logic                  MemToReg_in,
   input  logic                  Branch_in,
   input  logic [1:0]            MemSize_in,
   output logic [DATA_WIDTH-1:0] ALUResult_out,
   output logic [DATA_WIDTH-1:0] BranchTarget_out,
   output logic [DATA_WIDTH-1:0] WriteData_out,
   output logic [4:0]            RegDst_out,
   output logic                  RegWrite_out,
   output logic                  MemRead_out,
   output logic                  MemWrite_out,
   output logic                  MemToReg_out,
   output logic [1:0]            MemSize_out,
   output logic                  Valid_out,
   output logic                  BranchTaken_out,
   output logic [7:0]            BubbleCount_out
);

   // A load of a non-instruction is treated exactly like a flush; flush beats stall.
   logic bubble;
   assign bubble = Flush | (~Stall & ~Valid_in);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         ALUResult_out    <= '0;
         BranchTarget_out <= '0;
         WriteData_out    <= '0;
         RegDst_out       <= '0;
         RegWrite_out     <= 1'b0;
         MemRead_out      <= 1'b0;
         MemWrite_out     <= 1'b0;
         MemToReg_out     <= 1'b0;
         MemSize_out      <= '0;
         Valid_out        <= 1'b0;
         BranchTaken_out  <= 1'b0;
         BubbleCount_out  <= '0;
      end else if (bubble) begin
         ALUResult_out    <= '0;
         BranchTarget_out <= '0;
         WriteData_out    <= '0;
         RegDst_out       <= '0;
         RegWrite_out     <= 1'b0;
         MemRead_out      <= 1'b0;
         MemWrite_out     <= 1'b0;
         MemToReg_out     <= 1'b0;
         MemSize_out      <= '0;
         Valid_out        <= 1'b0;
         BranchTaken_out  <= 1'b0;
         if (BubbleCount_out != 8'hFF)
            BubbleCount_out <= BubbleCount_out + 8'd1;
      end else if (!Stall) begin
         ALUResult_out    <= ALUResult_in;
         BranchTarget_out <= BranchTarget_in;
         WriteData_out    <= WriteData_in;
         RegDst_out       <= RegDst_in;
         // Writes to $zero are dropped; a read+write conflict resolves to read.
         RegWrite_out     <= RegWrite_in & (RegDst_in != 5'd0);
         MemRead_out      <= MemRead_in;
         MemWrite_out     <= MemWrite_in & ~MemRead_in;
         MemToReg_out     <= MemToReg_in;
         MemSize_out      <= (MemSize_in == 2'b11) ? 2'b00 : MemSize_in;
         Valid_out        <= 1'b1;
         BranchTaken_out  <= Branch_in & Zero_in;
      end
   end

endmodule

// File: tb/tb_ex_mem_register.sv
// Randomized + directed bench for ex_mem_register against a field-level model.
module tb_ex_mem_register;
   localparam int DW = 32;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic          Reset, Stall, Flush, Valid_in, Zero_in;
   logic [DW-1:0] ALUResult_in, BranchTarget_in, WriteData_in;
   logic [4:0]    RegDst_in;
   logic          RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, Branch_in;
   logic [1:0]    MemSize_in;
   logic [DW-1:0] ALUResult_out, BranchTarget_out, WriteData_out;
   logic [4:0]    RegDst_out;
   logic          RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out;
   logic [1:0]    MemSize_out;
   logic          Valid_out, BranchTaken_out;
   logic [7:0]    BubbleCount_out;

   ex_mem_register #(.DATA_WIDTH(DW)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .Valid_in(Valid_in),
      .ALUResult_in(ALUResult_in), .Zero_in(Zero_in), .BranchTarget_in(BranchTarget_in),
      .WriteData_in(WriteData_in), .RegDst_in(RegDst_in), .RegWrite_in(RegWrite_in),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
      .Branch_in(Branch_in), .MemSize_in(MemSize_in),
      .ALUResult_out(ALUResult_out), .BranchTarget_out(BranchTarget_out),
      .WriteData_out(WriteData_out), .RegDst_out(RegDst_out), .RegWrite_out(RegWrite_out),
      .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
      .MemSize_out(MemSize_out), .Valid_out(Valid_out), .BranchTaken_out(BranchTaken_out),
      .BubbleCount_out(BubbleCount_out)
   );

   // expected register contents
   logic [DW-1:0] m_alu, m_bt, m_wd;
   logic [4:0]    m_rd;
   logic          m_rw, m_mr, m_mw, m_m2r, m_v, m_bk;
   logic [1:0]    m_ms;
   int            m_cnt;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_alu = '0; m_bt = '0; m_wd = '0; m_rd = '0; m_ms = '0;
      m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_v = 0; m_bk = 0;
   endtask

   // Evaluated from the inputs present at the edge.
   task automatic model_edge();
      if (!Reset) begin
         model_clear();
         m_cnt = 0;
      end else if (Flush || (!Stall && !Valid_in)) begin
         model_clear();
         m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end else if (!Stall) begin
         m_alu = ALUResult_in;
         m_bt  = BranchTarget_in;
         m_wd  = WriteData_in;
         m_rd  = RegDst_in;
         m_rw  = RegWrite_in && (RegDst_in != 0);
         m_mr  = MemRead_in;
         m_mw  = MemWrite_in && !MemRead_in;
         m_m2r = MemToReg_in;
         m_ms  = (MemSize_in == 3) ? 2'd0 : MemSize_in;
         m_v   = 1;
         m_bk  = Branch_in && Zero_in;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".alu"}, ALUResult_out, m_alu);
      chk({tag, ".bt"},  BranchTarget_out, m_bt);
      chk({tag, ".wd"},  WriteData_out, m_wd);
      chk({tag, ".rd"},  RegDst_out, m_rd);
      chk({tag, ".rw"},  RegWrite_out, m_rw);
      chk({tag, ".mr"},  MemRead_out, m_mr);
      chk({tag, ".mw"},  MemWrite_out, m_mw);
      chk({tag, ".m2r"}, MemToReg_out, m_m2r);
      chk({tag, ".ms"},  MemSize_out, m_ms);
      chk({tag, ".v"},   Valid_out, m_v);
      chk({tag, ".bk"},  BranchTaken_out, m_bk);
      chk({tag, ".cnt"}, BubbleCount_out, m_cnt[7:0]);
   endtask

   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_in();
      Reset = 1; Stall = 0; Flush = 0; Valid_in = 1; Zero_in = 0;
      ALUResult_in = '0; BranchTarget_in = '0; WriteData_in = '0; RegDst_in = '0;
      RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
      Branch_in = 0; MemSize_in = '0;
   endtask

   initial begin
      model_clear();
      m_cnt = 0;
      idle_in();
      Reset = 0;
      #2;
      step("reset");
      Reset = 1;

      // plain load
      ALUResult_in = 32'h0000000C; RegDst_in = 5'd8; RegWrite_in = 1;
      step("load");
      chk("load.alu_lit", ALUResult_out, 64'hC);
      chk("load.rd_lit", RegDst_out, 64'd8);

      // branch taken / not taken
      idle_in(); Branch_in = 1; Zero_in = 1; BranchTarget_in = 32'h00000040;
      step("br_t");
      chk("br_t.lit", BranchTaken_out, 64'd1);
      Zero_in = 0;
      step("br_nt");

      // stall hold for 3 edges, then release
      idle_in(); ALUResult_in = 32'hDEADBEEF;
      step("pre_stall");
      ALUResult_in = 32'h1; Stall = 1;
      for (int i = 0; i < 3; i++) step("stall");
      chk("stall.lit", ALUResult_out, 64'hDEADBEEF);
      Stall = 0;
      step("unstall");

      // flush beats stall
      Flush = 1; Stall = 1; MemWrite_in = 1;
      step("flush_stall");
      chk("flush_stall.cnt_lit", BubbleCount_out, 64'd1);

      // $zero write and read/write conflict, reserved size, invalid load
      idle_in(); RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 1; MemSize_in = 2'b11;
      step("sanitize");
      Valid_in = 0; ALUResult_in = 32'h55;
      step("invalid");
      Valid_in = 0; Stall = 1;
      step("invalid_stall");

      // reset mid-stall, then normal load
      idle_in(); ALUResult_in = 32'hA5A5A5A5;
      step("pre_rst");
      Stall = 1; Reset = 0;
      step("rst_stall");
      Reset = 1; Stall = 0; ALUResult_in = 32'h77;
      step("post_rst");

      // saturation
      idle_in(); Flush = 1;
      for (int i = 0; i < 260; i++) step("sat");
      chk("sat.lit", BubbleCount_out, 64'd255);
      Flush = 0; Reset = 0;
      step("sat_rst");

      // random traffic
      for (int i = 0; i < 600; i++) begin
         Reset           = ($urandom_range(0, 39) != 0);
         Stall           = ($urandom_range(0, 3) == 0);
         Flush           = ($urandom_range(0, 7) == 0);
         Valid_in        = ($urandom_range(0, 4) != 0);
         ALUResult_in    = $urandom;
         BranchTarget_in = $urandom;
         WriteData_in    = $urandom;
         RegDst_in       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
         {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in, Branch_in, Zero_in} = 6'($urandom);
         MemSize_in      = 2'($urandom);
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
